// File: rtl/dll_priority_dec.sv
// dll_priority_dec: rebuilds a linear magnitude from an MSB position code
// plus mantissa bits. It also produces a one-hot mask and a thermometer mask.
// Two register stages: stage 1 classifies the code, stage 2 holds the result.
// Ports:
//   clk, reset                  clock and async active-high reset
//   in_valid/in_ready, pos/mant input handshake and code
//   out_valid/out_ready         output handshake
//   value/onehot/therm          results
//   sat/err                     per-result flags
module dll_priority_dec #(
  parameter int WIDTH  = 39,
  parameter int POS_W  = 6,
  parameter int FLOOR  = 13,
  parameter int MANT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [POS_W-1:0]  pos,
  input  logic [MANT_W-1:0] mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  value,
  output logic [WIDTH-1:0]  onehot,
  output logic [WIDTH-1:0]  therm,
  output logic              sat,
  output logic              err
);

  typedef enum logic [1:0] {
    C_NORM  = 2'd0,
    C_FLOOR = 2'd1,
    C_SAT   = 2'd2
  } cls_e;

  localparam logic [POS_W-1:0] MAX_P   = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] FLOOR_P = POS_W'(FLOOR);
  localparam logic [POS_W-1:0] MANT_P  = POS_W'(MANT_W);
  localparam logic [WIDTH-1:0] FLOOR_T =
    {{(WIDTH-FLOOR-1){1'b0}}, {(FLOOR+1){1'b1}}};

  logic en;

  logic              v1_q, v1_d;
  cls_e              cls1_q, cls1_d;
  logic [POS_W-1:0]  p1_q, p1_d;
  logic [MANT_W-1:0] mant1_q, mant1_d;
  logic              sat1_q, sat1_d;
  logic              err1_q, err1_d;

  logic              ov_q, ov_d;
  logic [WIDTH-1:0]  val_q, val_d;
  logic [WIDTH-1:0]  oh_q, oh_d;
  logic [WIDTH-1:0]  th_q, th_d;
  logic              sat_q, sat_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  m_sh;

  // One global enable stalls every stage together.
  assign en       = !ov_q | out_ready;
  assign in_ready = en;

  always_comb begin
    v1_d    = in_valid;
    p1_d    = pos;
    mant1_d = mant;
    cls1_d  = C_NORM;
    sat1_d  = 1'b0;
    err1_d  = 1'b0;
    unique case (1'b1)
      (pos > MAX_P): begin
        cls1_d = C_SAT;
        sat1_d = 1'b1;
      end
      (pos < FLOOR_P): begin
        cls1_d = C_FLOOR;
        err1_d = 1'b1;
      end
      (pos == FLOOR_P): begin
        cls1_d = C_FLOOR;
      end
      default: begin
        cls1_d = C_NORM;
      end
    endcase
  end

  // Mantissa sits directly under the MSB. Bits that would fall
  // below bit 0 are shifted out.
  always_comb begin
    m_sh = '0;
    if (p1_q >= MANT_P) begin
      m_sh = WIDTH'(mant1_q) << (p1_q - MANT_P);
    end else begin
      m_sh = WIDTH'(mant1_q) >> (MANT_P - p1_q);
    end
  end

  always_comb begin
    ov_d  = v1_q;
    sat_d = sat1_q;
    err_d = err1_q;
    oh_d  = '0;
    th_d  = '0;
    val_d = '0;
    unique case (cls1_q)
      C_NORM: begin
        oh_d  = WIDTH'(1) << p1_q;
        // Bits [p:0] are set, so therm = onehot | (onehot - 1).
        th_d  = oh_d | (oh_d - WIDTH'(1));
        val_d = oh_d | m_sh;
      end
      C_FLOOR: begin
        th_d  = FLOOR_T;
      end
      default: begin
        th_d  = '1;
        val_d = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q    <= 1'b0;
      cls1_q  <= C_NORM;
      p1_q    <= '0;
      mant1_q <= '0;
      sat1_q  <= 1'b0;
      err1_q  <= 1'b0;
      ov_q    <= 1'b0;
      val_q   <= '0;
      oh_q    <= '0;
      th_q    <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else if (en) begin
      v1_q    <= v1_d;
      cls1_q  <= cls1_d;
      p1_q    <= p1_d;
      mant1_q <= mant1_d;
      sat1_q  <= sat1_d;
      err1_q  <= err1_d;
      ov_q    <= ov_d;
      val_q   <= val_d;
      oh_q    <= oh_d;
      th_q    <= th_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = ov_q;
  assign value     = val_q;
  assign onehot    = oh_q;
  assign therm     = th_q;
  assign sat       = sat_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dll_priority_dec.sv
// tb_dll_priority_dec: vector table, directed sequences, random traffic
// against an arithmetic reference model with an in-order scoreboard.
module tb_dll_priority_dec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  pos;
  logic [3:0]  mant;
  logic        out_valid;
  logic        out_ready;
  logic [38:0] value;
  logic [38:0] onehot;
  logic [38:0] therm;
  logic        sat;
  logic        err;

  dll_priority_dec dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pos       (pos),
    .mant      (mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value     (value),
    .onehot    (onehot),
    .therm     (therm),
    .sat       (sat),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [38:0] v;
    logic [38:0] oh;
    logic [38:0] th;
    logic        s;
    logic        e;
  } res_t;

  typedef struct {
    logic [5:0]  p;
    logic [3:0]  m;
    logic [38:0] v;
    logic [38:0] oh;
    logic [38:0] th;
    logic        s;
    logic        e;
  } vec_t;

  localparam logic [38:0] ALL1 = 39'h7F_FFFF_FFFF;

  int   checks   = 0;
  int   failures = 0;
  res_t q[$];

  logic        obs_ov;
  logic        obs_ir;
  logic        obs_acc;
  logic [38:0] obs_val;

  // Reference: magnitude = 2^p + mant * 2^(p-4), masks by plain powers of two.
  function automatic res_t model(input logic [5:0] p, input logic [3:0] m);
    res_t   r;
    longint pw;
    r.s = 1'b0;
    r.e = 1'b0;
    if (p > 6'd38) begin
      r.v  = ALL1;
      r.oh = '0;
      r.th = ALL1;
      r.s  = 1'b1;
    end else if (p <= 6'd13) begin
      r.v  = '0;
      r.oh = '0;
      r.th = 39'((64'd1 << 14) - 64'd1);
      r.e  = (p < 6'd13);
    end else begin
      pw   = longint'(64'd1 << p);
      r.oh = 39'(pw);
      r.th = 39'(2 * pw - 1);
      r.v  = 39'(pw + longint'(m) * (pw / 16));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Called at a falling edge; drives inputs, samples, returns at next negedge.
  task automatic cycle(input logic iv, input logic [5:0] p,
                       input logic [3:0] m, input logic ordy);
    res_t e;
    in_valid  = iv;
    pos       = p;
    mant      = m;
    out_ready = ordy;
    #1;
    obs_ov  = out_valid;
    obs_ir  = in_ready;
    obs_val = value;
    obs_acc = in_valid && in_ready && !reset;
    if (out_valid && out_ready && !reset) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("sb_value", 64'(value), 64'(e.v));
        chk("sb_onehot", 64'(onehot), 64'(e.oh));
        chk("sb_therm", 64'(therm), 64'(e.th));
        chk("sb_sat", 64'(sat), 64'(e.s));
        chk("sb_err", 64'(err), 64'(e.e));
      end
    end
    if (obs_acc) q.push_back(model(p, m));
    @(negedge clk);
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{6'd38, 4'hA, 39'h68_0000_0000, 39'h40_0000_0000, ALL1, 0, 0};
    tbl[1] = '{6'd13, 4'hF, 39'h0, 39'h0, 39'h3FFF, 0, 0};
    tbl[2] = '{6'd5,  4'hF, 39'h0, 39'h0, 39'h3FFF, 0, 1};
    tbl[3] = '{6'd45, 4'h7, ALL1, 39'h0, ALL1, 1, 0};
    tbl[4] = '{6'd14, 4'h3, 39'h4C00, 39'h4000, 39'h7FFF, 0, 0};
    tbl[5] = '{6'd20, 4'hF, 39'h1F_0000, 39'h10_0000, 39'h1F_FFFF, 0, 0};
    tbl[6] = '{6'd39, 4'h0, ALL1, 39'h0, ALL1, 1, 0};
    tbl[7] = '{6'd0,  4'h1, 39'h0, 39'h0, 39'h3FFF, 0, 1};

    reset     = 1'b1;
    in_valid  = 1'b1;
    pos       = 6'd20;
    mant      = 4'h1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_value", 64'(value), 64'd0);
    chk("rst_onehot", 64'(onehot), 64'd0);
    chk("rst_therm", 64'(therm), 64'd0);
    chk("rst_flags", 64'({sat, err}), 64'd0);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    foreach (tbl[i]) begin
      cycle(1'b1, tbl[i].p, tbl[i].m, 1'b1);
      cycle(1'b0, 6'd0, 4'd0, 1'b1);
      chk("tbl_latency", 64'(obs_ov), 64'd0);
      #1;
      chk("tbl_out_valid", 64'(out_valid), 64'd1);
      chk("tbl_value", 64'(value), 64'(tbl[i].v));
      chk("tbl_onehot", 64'(onehot), 64'(tbl[i].oh));
      chk("tbl_therm", 64'(therm), 64'(tbl[i].th));
      chk("tbl_sat", 64'(sat), 64'(tbl[i].s));
      chk("tbl_err", 64'(err), 64'(tbl[i].e));
    end
    repeat (2) cycle(1'b0, 6'd0, 4'd0, 1'b1);

    for (int i = 0; i < 28; i++) begin
      cycle(i < 25, 6'(14 + i), 4'(i), 1'b1);
      chk("stream_out_valid", 64'(obs_ov), 64'(i >= 2 && i <= 26));
    end
    chk("stream_drained", 64'(q.size()), 64'd0);

    begin
      int          idx;
      logic [38:0] held;
      idx  = 0;
      held = '0;
      for (int c = 0; c < 30; c++) begin
        if (idx == 4 && q.size() == 0 && c > 8) break;
        cycle(idx < 4, 6'(24 + idx), 4'(idx + 5), !(c >= 2 && c <= 6));
        if (obs_acc) idx++;
        if (c >= 2 && c <= 6) begin
          chk("bp_in_ready", 64'(obs_ir), 64'd0);
          chk("bp_out_valid", 64'(obs_ov), 64'd1);
          if (c == 2) held = obs_val;
          else chk("bp_hold", 64'(obs_val), 64'(held));
        end
      end
      chk("bp_accepted", 64'(idx), 64'd4);
      chk("bp_drained", 64'(q.size()), 64'd0);
    end
    repeat (2) cycle(1'b0, 6'd0, 4'd0, 1'b1);

    cycle(1'b1, 6'd20, 4'd5, 1'b1);
    cycle(1'b1, 6'd21, 4'd6, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_value", 64'(value), 64'd0);
    q.delete();
    in_valid = 1'b1;
    pos      = 6'd30;
    @(negedge clk);
    @(negedge clk);
    chk("in_rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 6'd0, 4'd0, 1'b1);
      chk("post_rst_stale", 64'(obs_ov), 64'd0);
    end
    cycle(1'b1, 6'd22, 4'd1, 1'b1);
    cycle(1'b0, 6'd0, 4'd0, 1'b1);
    chk("post_rst_lat1", 64'(obs_ov), 64'd0);
    cycle(1'b0, 6'd0, 4'd0, 1'b1);
    chk("post_rst_lat2", 64'(obs_ov), 64'd1);

    for (int i = 0; i < 400; i++) begin
      logic [5:0] rp;
      if ($urandom_range(0, 1) == 0) rp = 6'($urandom_range(0, 63));
      else rp = 6'($urandom_range(11, 40));
      cycle($urandom_range(0, 3) != 0, rp, 4'($urandom_range(0, 15)),
            $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 6'd0, 4'd0, 1'b1);
    chk("rand_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
